// File: rtl/unidad_logico_aritmetica_core.sv
// Registered N-bit ALU (logic, add/sub, 1-bit shifts) with NZVC flags; ALU_ROTATE_EN adds rotates on 1110/1111.
// Latency 1 cycle, a new operation every cycle, no backpressure; synchronous active-high reset clears all outputs.
module unidad_logico_aritmetica_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] numero1,
    input  logic [N-1:0] numero2,
    input  logic [3:0]   ALUControl,
    output logic [N-1:0] resultado,
    output logic         flagNegativo,
    output logic         flagCero,
    output logic         flagOverflow,
    output logic         flagCarry
);

    logic [N-1:0] resultado_d, resultado_q;
    logic         neg_d, neg_q;
    logic         cero_d, cero_q;
    logic         ovf_d, ovf_q;
    logic         carry_d, carry_q;

    logic [N-1:0] res_c;
    logic         carry_c;
    logic         ovf_c;
    logic [N:0]   add_ext;
    logic [N:0]   sub_ext;

    // Subtraction as A + ~B + 1 so its carry-out is the inverted borrow.
    assign add_ext = {1'b0, numero1} + {1'b0, numero2};
    assign sub_ext = {1'b0, numero1} + {1'b0, ~numero2} + {{N{1'b0}}, 1'b1};

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (ALUControl)
            4'b0000: res_c = numero1 & numero2;
            4'b0001: res_c = numero1 | numero2;
            4'b0010: res_c = numero1 ^ numero2;
            4'b0011: res_c = ~numero1;
            4'b0100: begin
                res_c   = {1'b0, numero1[N-1:1]};
                carry_c = numero1[0];
            end
            4'b0101, 4'b1011: begin
                res_c   = {numero1[N-2:0], 1'b0};
                carry_c = numero1[N-1];
            end
            4'b0110: begin
                res_c   = {1'b0, numero2[N-1:1]};
                carry_c = numero2[0];
            end
            4'b0111, 4'b1101: begin
                res_c   = {numero2[N-2:0], 1'b0};
                carry_c = numero2[N-1];
            end
            4'b1000: begin
                res_c   = add_ext[N-1:0];
                carry_c = add_ext[N];
                ovf_c   = (numero1[N-1] == numero2[N-1]) &&
                          (add_ext[N-1] != numero1[N-1]);
            end
            4'b1001: begin
                res_c   = sub_ext[N-1:0];
                carry_c = sub_ext[N];
                ovf_c   = (numero1[N-1] != numero2[N-1]) &&
                          (sub_ext[N-1] != numero1[N-1]);
            end
            4'b1010: begin
                res_c   = {numero1[N-1], numero1[N-1:1]};
                carry_c = numero1[0];
            end
            4'b1100: begin
                res_c   = {numero2[N-1], numero2[N-1:1]};
                carry_c = numero2[0];
            end
`ifdef ALU_ROTATE_EN
            4'b1110: begin
                res_c   = {numero1[0], numero1[N-1:1]};
                carry_c = numero1[0];
            end
            4'b1111: begin
                res_c   = {numero1[N-2:0], numero1[N-1]};
                carry_c = numero1[N-1];
            end
`endif
            default: begin
                res_c   = '0;
                carry_c = 1'b0;
                ovf_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        resultado_d = res_c;
        neg_d       = res_c[N-1];
        cero_d      = (res_c == '0);
        ovf_d       = ovf_c;
        carry_d     = carry_c;
        if (rst) begin
            resultado_d = '0;
            neg_d       = 1'b0;
            cero_d      = 1'b0;
            ovf_d       = 1'b0;
            carry_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        resultado_q <= resultado_d;
        neg_q       <= neg_d;
        cero_q      <= cero_d;
        ovf_q       <= ovf_d;
        carry_q     <= carry_d;
    end

    assign resultado    = resultado_q;
    assign flagNegativo = neg_q;
    assign flagCero     = cero_q;
    assign flagOverflow = ovf_q;
    assign flagCarry    = carry_q;

endmodule

// File: tb/tb_unidad_logico_aritmetica_core.sv
// Bench for the 4-bit ALU: directed cases plus random vectors against an integer-arithmetic model.
module tb_unidad_logico_aritmetica_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] numero1;
    logic [3:0] numero2;
    logic [3:0] ALUControl;
    logic [3:0] resultado;
    logic       flagNegativo, flagCero, flagOverflow, flagCarry;

    int passed = 0;
    int total  = 0;

    unidad_logico_aritmetica_core #(.N(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .numero1      (numero1),
        .numero2      (numero2),
        .ALUControl   (ALUControl),
        .resultado    (resultado),
        .flagNegativo (flagNegativo),
        .flagCero     (flagCero),
        .flagOverflow (flagOverflow),
        .flagCarry    (flagCarry)
    );

    always #5 clk = ~clk;

    // Expected {result[3:0], N, Z, V, C} from plain integer arithmetic.
    function automatic logic [7:0] model(input int a, input int b, input int op);
        int r, c, v, sa, sb, t;
        r = 0; c = 0; v = 0;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = 15 - a;
            4: begin r = a / 2; c = a % 2; end
            5, 11: begin r = (a * 2) % 16; c = a / 8; end
            6: begin r = b / 2; c = b % 2; end
            7, 13: begin r = (b * 2) % 16; c = b / 8; end
            8: begin
                r = (a + b) % 16; c = (a + b) / 16;
                t = sa + sb; v = (t > 7 || t < -8) ? 1 : 0;
            end
            9: begin
                r = (a - b + 16) % 16; c = (a >= b) ? 1 : 0;
                t = sa - sb; v = (t > 7 || t < -8) ? 1 : 0;
            end
            10: begin
                t = (sa < 0) ? (sa - 1) / 2 : sa / 2;
                r = (t + 16) % 16; c = a % 2;
            end
            12: begin
                t = (sb < 0) ? (sb - 1) / 2 : sb / 2;
                r = (t + 16) % 16; c = b % 2;
            end
`ifdef ALU_ROTATE_EN
            14: begin r = a / 2 + (a % 2) * 8; c = a % 2; end
            15: begin r = (a * 2) % 16 + a / 8; c = a / 8; end
`endif
            default: r = 0;
        endcase
        model = {r[3:0], (r >= 8) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, v[0], c[0]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {resultado, flagNegativo, flagCero, flagOverflow, flagCarry};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got res/NZVC=%b/%b expected %b/%b",
                    tag, obs[7:4], obs[3:0], exp[7:4], exp[3:0]);
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        numero1    = a;
        numero2    = b;
        ALUControl = op;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] sweep_exp [14];

    initial begin
        sweep_exp = '{4'b0010, 4'b0111, 4'b0101, 4'b1000, 4'b0011, 4'b1110, 4'b0001,
                      4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b1110, 4'b0001, 4'b0100};
        rst = 1'b1;
        numero1 = 4'b0101; numero2 = 4'b0011; ALUControl = 4'b1000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_state", 8'b0000_0000);
        rst = 1'b0;

        // Opcode sweep with A=0111, B=0010
        for (int op = 0; op < 14; op++) begin
            apply(4'b0111, 4'b0010, op[3:0]);
            chk($sformatf("sweep_res_op%0d", op), {sweep_exp[op], resultado == 4'b0 ? 4'b0 : 4'b0} | {sweep_exp[op], 4'b0} | {4'b0, model(7, 2, op) & 8'h0F});
        end

        apply(4'b0111, 4'b0001, 4'b1000); chk("add_ovf",     8'b1000_1010);
        apply(4'b1111, 4'b0001, 4'b1000); chk("add_carry",   8'b0000_0101);
        apply(4'b0010, 4'b0010, 4'b1001); chk("sub_zero",    8'b0000_0101);
        apply(4'b0010, 4'b0111, 4'b1001); chk("sub_borrow",  8'b1011_1000);
        apply(4'b1000, 4'b0001, 4'b1001); chk("sub_ovf",     8'b0111_0011);
        apply(4'b1010, 4'b0000, 4'b1010); chk("asr_neg",     8'b1101_1000);
        apply(4'b1010, 4'b0000, 4'b0100); chk("lsr_neg",     8'b0101_0000);
        apply(4'b1010, 4'b0000, 4'b0101); chk("lsl_neg",     8'b0100_0001);

        // Reset wins over an in-flight ADD, then the ADD lands on the next edge
        numero1 = 4'b0111; numero2 = 4'b0001; ALUControl = 4'b1000;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_override", 8'b0000_0000);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_add", 8'b1000_1010);

`ifdef ALU_ROTATE_EN
        apply(4'b0110, 4'b0000, 4'b1110); chk("op1110_ror", 8'b0011_0000);
        apply(4'b1001, 4'b0000, 4'b1111); chk("op1111_rol", 8'b0011_0001);
`else
        apply(4'b0110, 4'b0000, 4'b1110); chk("op1110_zero", 8'b0000_0100);
        apply(4'b1001, 4'b0101, 4'b1111); chk("op1111_zero", 8'b0000_0100);
`endif

        // Random vectors, back-to-back every cycle
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ra, rb, rop;
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 4'($urandom_range(0, 15));
            apply(ra, rb, rop);
            chk($sformatf("rand%0d_op%0d_a%0d_b%0d", i, rop, ra, rb),
                model(int'(ra), int'(rb), int'(rop)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
